gb_cpu_bus_ctrl: RTL and testbench

GB_CPU_BUS_CTRL -- requirements
Module: gb_cpu_bus_ctrl

---
 rtl/gb_cpu_bus_ctrl.sv | 164 ++++++++++++++++
 tb/tb_gb_cpu_bus_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gb_cpu_bus_ctrl.sv
// rtl/gb_cpu_bus_ctrl.sv - CPU memory-bus cycle controller (T1..T4 with T3 wait states and timeout)
// Shared regfile byte-register encoding; only IR/TMP_L/TMP_H are legal read destinations here.
package gb_cpu_bus_pkg;
    typedef enum logic [3:0] {
        REG_IR, REG_TMP_L, REG_TMP_H, REG_A, REG_F, REG_B, REG_C, REG_D,
        REG_E, REG_H, REG_L, REG_SP_L, REG_SP_H, REG_PC_L, REG_PC_H, REG_NONE
    } regfile_r8_t;
endpackage

module gb_cpu_bus_ctrl
    import gb_cpu_bus_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  regfile_r8_t req_dest,
    output logic        req_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output regfile_r8_t data_bus_req,
    output logic [7:0]  data_bus_data,
    output logic        data_bus_wren,
    output logic        mcycle_done,
    output logic        bus_err
);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        write_q, write_d;
    regfile_r8_t dest_q, dest_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        wren_q, wren_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic        accept;
    logic        dest_legal;

    assign accept     = req_valid && ready_q;
    assign dest_legal = (dest_q == REG_IR) || (dest_q == REG_TMP_L) || (dest_q == REG_TMP_H);

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        write_d     = write_q;
        dest_d      = dest_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        wren_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE, S_T4: begin
                if (accept) begin
                    state_d     = S_T1;
                    wait_d      = 4'd0;
                    write_d     = req_write;
                    dest_d      = req_dest;
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T1: begin
                state_d  = S_T2;
                mem_rd_d = !write_q;
                mem_wr_d = write_q;
            end
            S_T2: begin
                state_d  = S_T3;
                mem_rd_d = !write_q;
                mem_wr_d = write_q;
            end
            S_T3: begin
                if (mem_ready) begin
                    state_d = S_T4;
                    done_d  = 1'b1;
                    if (!write_q) begin
                        rdata_d = mem_rdata;
                        wren_d  = dest_legal;
                        err_d   = !dest_legal;
                    end
                end else if (wait_q == MAX_WAIT_C) begin
                    // Timed out: drop the cycle without completing it.
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_d   = wait_q + 4'd1;
                    mem_rd_d = !write_q;
                    mem_wr_d = write_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE) || (state_d == S_T4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_q      <= 4'd0;
            write_q     <= 1'b0;
            dest_q      <= REG_IR;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            rdata_q     <= 8'h00;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            wren_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            write_q     <= write_d;
            dest_q      <= dest_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            wren_q      <= wren_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
        end
    end

    assign req_ready     = ready_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_rd        = mem_rd_q;
    assign mem_wr        = mem_wr_q;
    assign data_bus_req  = dest_q;
    assign data_bus_data = rdata_q;
    assign data_bus_wren = wren_q;
    assign mcycle_done   = done_q;
    assign bus_err       = err_q;

endmodule

// File: tb/tb_gb_cpu_bus_ctrl.sv
// tb/tb_gb_cpu_bus_ctrl.sv - bench for gb_cpu_bus_ctrl
// Transactions are laid out on a cycle timeline; expected outputs come from that timeline.
module tb_gb_cpu_bus_ctrl;
    import gb_cpu_bus_pkg::*;

    localparam int MAXW = 15;
    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_ready;
    logic [15:0] req_addr, mem_addr;
    logic [7:0]  req_wdata, mem_wdata, mem_rdata, data_bus_data;
    regfile_r8_t req_dest, data_bus_req;
    logic        mem_rd, mem_wr, mem_ready, data_bus_wren, mcycle_done, bus_err;

    gb_cpu_bus_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_dest(req_dest), .req_ready(req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .data_bus_req(data_bus_req), .data_bus_data(data_bus_data),
        .data_bus_wren(data_bus_wren), .mcycle_done(mcycle_done), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    logic        st_valid[MAXC], st_write[MAXC], st_mready[MAXC];
    logic [15:0] st_addr[MAXC];
    logic [7:0]  st_wdata[MAXC], st_rdata[MAXC];
    regfile_r8_t st_dest[MAXC];

    logic        ex_rd[MAXC], ex_wr[MAXC], ex_ready[MAXC], ex_wren[MAXC];
    logic        ex_done[MAXC], ex_err[MAXC], ex_wd_chk[MAXC];
    logic [15:0] ex_addr[MAXC];
    logic [7:0]  ex_wdata[MAXC], ex_data[MAXC];
    regfile_r8_t ex_dest[MAXC];

    int vectors = 0;
    int miscompares = 0;
    int cur_cyc = -1;
    int ncyc;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cur_cyc, obs, exp);
        end
    endtask

    function automatic regfile_r8_t pick_dest();
        if ($urandom_range(0, 3) == 0) return regfile_r8_t'(4'($urandom_range(0, 15)));
        case ($urandom_range(0, 2))
            0:       return REG_IR;
            1:       return REG_TMP_L;
            default: return REG_TMP_H;
        endcase
    endfunction

    // Place one access presented at cycle a with `waits` not-ready T3 cycles; returns its last cycle.
    task automatic add_txn(input int a, input logic w, input logic [15:0] addr,
                           input logic [7:0] wd, input regfile_r8_t d, input int waits,
                           output int endc);
        bit tmo;
        int nt3;
        tmo = (waits > MAXW);
        nt3 = tmo ? MAXW + 1 : waits + 1;
        st_valid[a] = 1'b1; st_write[a] = w; st_addr[a] = addr;
        st_wdata[a] = wd;   st_dest[a]  = d;
        for (int c = a + 1; c < MAXC; c++) ex_addr[c] = addr;
        for (int c = a + 1; c < a + 3 + nt3; c++) ex_ready[c] = 1'b0;
        for (int c = a + 2; c < a + 3 + nt3; c++) begin
            ex_rd[c] = !w; ex_wr[c] = w; ex_wd_chk[c] = w; ex_wdata[c] = wd;
        end
        for (int j = 0; j < nt3; j++) st_mready[a + 3 + j] = (j >= waits);
        endc = a + 3 + nt3;
        if (tmo) begin
            ex_err[endc] = 1'b1;
        end else begin
            ex_done[endc] = 1'b1;
            if (!w) begin
                if (d == REG_IR || d == REG_TMP_L || d == REG_TMP_H) begin
                    ex_wren[endc] = 1'b1;
                    ex_data[endc] = st_rdata[endc - 1];
                    ex_dest[endc] = d;
                end else begin
                    ex_err[endc] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int a, e, r, waits;

        reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 16'hBEEF;
        req_wdata = 8'h5A; req_dest = REG_TMP_H; mem_ready = 1'b1; mem_rdata = 8'h77;

        for (int c = 0; c < MAXC; c++) begin
            st_valid[c] = 1'b0; st_write[c] = 1'($urandom); st_mready[c] = 1'($urandom);
            st_addr[c] = 16'($urandom); st_wdata[c] = 8'($urandom); st_rdata[c] = 8'($urandom);
            st_dest[c] = regfile_r8_t'(4'($urandom_range(0, 15)));
            ex_rd[c] = 1'b0; ex_wr[c] = 1'b0; ex_ready[c] = 1'b1; ex_wren[c] = 1'b0;
            ex_done[c] = 1'b0; ex_err[c] = 1'b0; ex_wd_chk[c] = 1'b0; ex_addr[c] = 16'h0000;
            ex_wdata[c] = 8'h00; ex_data[c] = 8'h00; ex_dest[c] = REG_IR;
        end

        a = 0;
        add_txn(a, 1'b0, 16'h0150, 8'h00, REG_IR, 0, e);      a = e + 1;
        add_txn(a, 1'b1, 16'hFF80, 8'hA5, REG_IR, 0, e);      a = e + 1;
        add_txn(a, 1'b0, 16'hC000, 8'h11, REG_TMP_L, 3, e);   a = e + 1;
        add_txn(a, 1'b0, 16'h4000, 8'h22, REG_TMP_H, 16, e);  a = e + 1;
        add_txn(a, 1'b0, 16'h1234, 8'h33, REG_IR, 0, e);      a = e;
        add_txn(a, 1'b0, 16'h1235, 8'h44, REG_TMP_H, 0, e);   a = e + 1;
        add_txn(a, 1'b0, 16'h2000, 8'h55, REG_A, 0, e);       a = e + 1;
        add_txn(a, 1'b1, 16'h9FFF, 8'h66, REG_IR, 15, e);     a = e;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            waits = (r == 0) ? 16 + $urandom_range(0, 2) : (r == 1) ? 15 : $urandom_range(0, 3);
            add_txn(a, 1'($urandom), 16'($urandom), 8'($urandom), pick_dest(), waits, e);
            a = e + $urandom_range(0, 2);
        end
        ncyc = a + 3;
        // Busy cycles get random req_valid, which the DUT must ignore.
        for (int c = 0; c < ncyc; c++) if (!ex_ready[c]) st_valid[c] = 1'($urandom);

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready", 16'(req_ready), 16'd1);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_wdata", 16'(mem_wdata), 16'h0000);
        chk("rst_rd", 16'(mem_rd), 16'd0);
        chk("rst_wr", 16'(mem_wr), 16'd0);
        chk("rst_wren", 16'(data_bus_wren), 16'd0);
        chk("rst_data", 16'(data_bus_data), 16'h0000);
        chk("rst_dest", 16'(data_bus_req), 16'(REG_IR));
        chk("rst_done", 16'(mcycle_done), 16'd0);
        chk("rst_err", 16'(bus_err), 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int c = 0; c < ncyc; c++) begin
            cur_cyc = c;
            req_valid = st_valid[c]; req_write = st_write[c]; req_addr = st_addr[c];
            req_wdata = st_wdata[c]; req_dest = st_dest[c];
            mem_ready = st_mready[c]; mem_rdata = st_rdata[c];
            @(negedge clk);
            chk("ready", 16'(req_ready), 16'(ex_ready[c]));
            chk("mem_rd", 16'(mem_rd), 16'(ex_rd[c]));
            chk("mem_wr", 16'(mem_wr), 16'(ex_wr[c]));
            chk("mem_addr", mem_addr, ex_addr[c]);
            chk("wren", 16'(data_bus_wren), 16'(ex_wren[c]));
            chk("done", 16'(mcycle_done), 16'(ex_done[c]));
            chk("bus_err", 16'(bus_err), 16'(ex_err[c]));
            if (ex_wd_chk[c]) chk("mem_wdata", 16'(mem_wdata), 16'(ex_wdata[c]));
            if (ex_wren[c]) begin
                chk("rd_data", 16'(data_bus_data), 16'(ex_data[c]));
                chk("rd_dest", 16'(data_bus_req), 16'(ex_dest[c]));
            end
            @(posedge clk);
            #1;
        end

        cur_cyc = ncyc;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h8001; req_dest = REG_TMP_L;
        mem_ready = 1'b0;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_rd", 16'(mem_rd), 16'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_rd", 16'(mem_rd), 16'd0);
        chk("rst_mid_wr", 16'(mem_wr), 16'd0);
        chk("rst_mid_wren", 16'(data_bus_wren), 16'd0);
        chk("rst_mid_done", 16'(mcycle_done), 16'd0);
        chk("rst_mid_err", 16'(bus_err), 16'd0);
        chk("rst_mid_ready", 16'(req_ready), 16'd1);
        chk("rst_mid_addr", mem_addr, 16'h0000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_done", 16'(mcycle_done), 16'd0);
        chk("post_rst_wren", 16'(data_bus_wren), 16'd0);
        chk("post_rst_rd", 16'(mem_rd), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
